// File: rtl/hazard_controller.sv
// Hazard sequencing for the 5-stage core: load-use stalls, taken-branch flushes, data-memory freezes.
// Optional HAZARD_PERF_EN macro adds saturating stall/flush/freeze event counters.
module hazard_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 16,
  parameter int WAIT_W     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic                  mem_branch_taken,
  input  logic                  mem_access,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  exmem_flush,
  output logic                  pipe_write,
  output logic                  memwb_bubble,
  output logic                  mem_timeout,
  output logic [1:0]            state
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count,
  output logic [31:0]           freeze_count
`endif
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] FREEZE = 2'd1;
  localparam logic [1:0] ERROR  = 2'd2;

  logic [1:0]        next_state;
  logic [WAIT_W-1:0] wait_cnt, next_cnt;
  logic              next_timeout;
  logic              freeze, lu_hazard, freeze_pat;

  assign freeze     = mem_access & ~dmem_ready;
  assign lu_hazard  = ex_memread & (ex_rd != '0) &
                      ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
  // ERROR holds the pipeline exactly as a live freeze would
  assign freeze_pat = (state == ERROR) | freeze;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= next_state;
      wait_cnt    <= next_cnt;
      mem_timeout <= next_timeout;
    end
  end

  always_comb begin
    next_state   = state;
    next_cnt     = wait_cnt;
    next_timeout = mem_timeout;
    case (state)
      RUN: begin
        if (freeze) begin
          next_state = FREEZE;
          next_cnt   = WAIT_W'(1);
        end else begin
          next_cnt   = '0;
        end
      end
      FREEZE: begin
        // mem_access dropping counts as completion, same as dmem_ready
        if (!freeze) begin
          next_state = RUN;
          next_cnt   = '0;
        end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
          next_state   = ERROR;
          next_timeout = 1'b1;
        end else begin
          next_cnt = wait_cnt + 1'b1;
        end
      end
      ERROR:   next_state = ERROR;
      default: begin
        next_state = RUN;
        next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_flush  = 1'b0;
    pipe_write   = 1'b1;
    memwb_bubble = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      pipe_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_flush  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (freeze_pat) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      pipe_write   = 1'b0;
      memwb_bubble = 1'b1;
    end else if (mem_branch_taken) begin
      // ID instruction is squashed, so a concurrent load-use is moot
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else if (lu_hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic stall_act, flush_act, freeze_act;
  assign freeze_act = ~reset & freeze_pat;
  assign flush_act  = ~reset & ~freeze_pat & mem_branch_taken;
  assign stall_act  = ~reset & ~freeze_pat & ~mem_branch_taken & lu_hazard;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count  <= '0;
      flush_count  <= '0;
      freeze_count <= '0;
    end else begin
      if (stall_act  && stall_count  != '1) stall_count  <= stall_count  + 1'b1;
      if (flush_act  && flush_count  != '1) flush_count  <= flush_count  + 1'b1;
      if (freeze_act && freeze_count != '1) freeze_count <= freeze_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus randomized traffic
// against a rule-level reference model.
module tb_hazard_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_memread, mem_branch_taken, mem_access, dmem_ready;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush;
  logic       pipe_write, memwb_bubble, mem_timeout;
  logic [1:0] state;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count, flush_count, freeze_count;
`endif

  hazard_controller dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_branch_taken(mem_branch_taken), .mem_access(mem_access),
    .dmem_ready(dmem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
    .pipe_write(pipe_write), .memwb_bubble(memwb_bubble),
    .mem_timeout(mem_timeout), .state(state)
`ifdef HAZARD_PERF_EN
    , .stall_count(stall_count), .flush_count(flush_count), .freeze_count(freeze_count)
`endif
  );

  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_write, memwb_bubble}
  localparam logic [6:0] P_RESET  = 7'b0011101;
  localparam logic [6:0] P_FREEZE = 7'b0000001;
  localparam logic [6:0] P_BRANCH = 7'b1111110;
  localparam logic [6:0] P_STALL  = 7'b0001010;
  localparam logic [6:0] P_DEF    = 7'b1100010;

  logic [6:0] obs;
  assign obs = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_write, memwb_bubble};

  int checks = 0;
  int errors = 0;

  // reference model: mode 0 running, 1 waiting on memory, 2 timed out
  int          m_mode = 0;
  int          m_wait = 0;
  logic        m_to = 1'b0;
  logic [31:0] m_stall = 0, m_flush = 0, m_frz = 0;

  function automatic logic model_lu();
    return ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
  endfunction

  function automatic logic [6:0] model_out();
    if (reset) return P_RESET;
    if (m_mode == 2 || (mem_access && !dmem_ready)) return P_FREEZE;
    if (mem_branch_taken) return P_BRANCH;
    if (model_lu()) return P_STALL;
    return P_DEF;
  endfunction

  task automatic tick();
    logic fz;
    @(posedge clk);
    fz = mem_access && !dmem_ready;
    if (reset) begin
      m_mode = 0; m_wait = 0; m_to = 1'b0;
      m_stall = 0; m_flush = 0; m_frz = 0;
    end else begin
      if (m_mode == 2 || fz) begin if (m_frz != '1) m_frz++; end
      else if (mem_branch_taken) begin if (m_flush != '1) m_flush++; end
      else if (model_lu()) begin if (m_stall != '1) m_stall++; end
      if (m_mode == 0) begin
        if (fz) begin m_mode = 1; m_wait = 1; end
      end else if (m_mode == 1) begin
        if (!fz) begin m_mode = 0; m_wait = 0; end
        else if (m_wait == 15) begin m_mode = 2; m_to = 1'b1; end
        else m_wait++;
      end
    end
    #1;
  endtask

  task automatic set_in(input int rs1, input int rs2, input bit u2, input int rd,
                        input bit mr, input bit br, input bit acc, input bit rdy);
    id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_uses_rs2 = u2; ex_rd = 5'(rd);
    ex_memread = mr; mem_branch_taken = br; mem_access = acc; dmem_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(5, 5, 1, 5, 1, 1, 1, 0);
    checks++;
    if (obs !== P_RESET) begin errors++; $display("FAIL reset_outs got %b exp %b", obs, P_RESET); end
    tick();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (state !== 2'd0 || mem_timeout !== 1'b0 || obs !== P_DEF) begin
      errors++; $display("FAIL reset_state got st=%0d to=%b outs=%b exp st=0 to=0 outs=%b", state, mem_timeout, obs, P_DEF);
    end
  endtask

  task automatic test_load_use();
    set_in(5, 0, 0, 5, 1, 0, 0, 1);
    checks++;
    if (obs !== P_STALL) begin errors++; $display("FAIL lu_stall got %b exp %b", obs, P_STALL); end
    tick();
    set_in(5, 0, 0, 5, 0, 0, 0, 1);
    checks++;
    if (obs !== P_DEF) begin errors++; $display("FAIL lu_release got %b exp %b", obs, P_DEF); end
    tick();
  endtask

  task automatic test_x0_rs2();
    set_in(0, 0, 1, 0, 1, 0, 0, 1);
    checks++;
    if (obs !== P_DEF) begin errors++; $display("FAIL x0_nostall got %b exp %b", obs, P_DEF); end
    set_in(1, 7, 0, 7, 1, 0, 0, 1);
    checks++;
    if (obs !== P_DEF) begin errors++; $display("FAIL rs2_unused got %b exp %b", obs, P_DEF); end
    set_in(1, 7, 1, 7, 1, 0, 0, 1);
    checks++;
    if (obs !== P_STALL) begin errors++; $display("FAIL rs2_used got %b exp %b", obs, P_STALL); end
    tick();
  endtask

  task automatic test_branch();
    set_in(5, 0, 0, 5, 1, 1, 0, 1);
    checks++;
    if (obs !== P_BRANCH) begin errors++; $display("FAIL branch_over_lu got %b exp %b", obs, P_BRANCH); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_freeze();
    set_in(5, 0, 0, 5, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== P_FREEZE || state !== ((i == 0) ? 2'd0 : 2'd1)) begin
        errors++; $display("FAIL freeze_cyc%0d got outs=%b st=%0d exp outs=%b", i, obs, state, P_FREEZE);
      end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    checks++;
    if (obs !== P_DEF || state !== 2'd1) begin
      errors++; $display("FAIL freeze_done got outs=%b st=%0d exp outs=%b st=1", obs, state, P_DEF);
    end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (obs !== P_DEF || state !== 2'd0) begin
      errors++; $display("FAIL freeze_exit got outs=%b st=%0d exp outs=%b st=0", obs, state, P_DEF);
    end
    tick();
  endtask

  task automatic test_timeout();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) begin
        checks++;
        if (state !== 2'd1 || mem_timeout !== 1'b0) begin
          errors++; $display("FAIL to_edge15 got st=%0d to=%b exp st=1 to=0", state, mem_timeout);
        end
      end
    end
    checks++;
    if (state !== 2'd2 || mem_timeout !== 1'b1) begin
      errors++; $display("FAIL to_edge16 got st=%0d to=%b exp st=2 to=1", state, mem_timeout);
    end
    set_in(3, 0, 0, 3, 1, 1, 0, 1);
    checks++;
    if (obs !== P_FREEZE) begin errors++; $display("FAIL error_hold got %b exp %b", obs, P_FREEZE); end
    tick();
    checks++;
    if (state !== 2'd2 || mem_timeout !== 1'b1) begin
      errors++; $display("FAIL error_sticky got st=%0d to=%b exp st=2 to=1", state, mem_timeout);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (state !== 2'd0 || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL error_reset got st=%0d to=%b exp st=0 to=0", state, mem_timeout);
    end
  endtask

  task automatic test_reset_mid_freeze();
    set_in(5, 0, 0, 5, 1, 1, 1, 0);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL midreset_state got %0d exp 0", state); end
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_count !== 0 || flush_count !== 0 || freeze_count !== 0) begin
      errors++; $display("FAIL midreset_perf got %0d %0d %0d exp 0 0 0", stall_count, flush_count, freeze_count);
    end
`endif
    reset = 1'b0;
    // a cleared wait counter means a full 16 cycles are needed again to time out
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) begin
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL midreset_cnt15 got %0d exp 1", state); end
      end
    end
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL midreset_cnt16 got %0d exp 2", state); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
      checks++;
      if (obs !== model_out() || state !== 2'(m_mode) || mem_timeout !== m_to) begin
        errors++;
        $display("FAIL rand%0d got outs=%b st=%0d to=%b exp outs=%b st=%0d to=%b",
                 n, obs, state, mem_timeout, model_out(), m_mode, m_to);
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (stall_count !== m_stall || flush_count !== m_flush || freeze_count !== m_frz) begin
        errors++;
        $display("FAIL rand_perf%0d got %0d %0d %0d exp %0d %0d %0d", n, stall_count,
                 flush_count, freeze_count, m_stall, m_flush, m_frz);
      end
`endif
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_rs2();
    test_branch();
    test_freeze();
    test_timeout();
    test_reset_mid_freeze();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
